// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - round-robin sharing of one combinational FP add/sub unit
// Optional macro: FP_ARB_BACK2BACK_EN (grant the next winner from RESP on response accept)
module fp_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_sub,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_exception,
  output logic [DATA_W-1:0]         fpu_a,
  output logic [DATA_W-1:0]         fpu_b,
  output logic                      fpu_sub,
  input  logic [DATA_W-1:0]         fpu_result,
  input  logic                      fpu_exception,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   fpu_a_q, fpu_a_d;
  logic [DATA_W-1:0]   fpu_b_q, fpu_b_d;
  logic                fpu_sub_q, fpu_sub_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_result_q, resp_result_d;
  logic                resp_exception_q, resp_exception_d;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W:0]       cand;
  logic                grant_en;
  logic                grant;
  logic [DATA_W-1:0]   a_sel, b_sel;
  logic                sub_sel;

  // Round-robin search for the first valid requester starting at rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

`ifdef FP_ARB_BACK2BACK_EN
  assign grant_en = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
`else
  assign grant_en = (state_q == IDLE);
`endif
  assign grant = grant_en && win_found;

  // One-hot grant and operand selection for the winning requester
  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    sub_sel   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        req_ready[i] = grant;
        a_sel        = req_a[i*DATA_W +: DATA_W];
        b_sel        = req_b[i*DATA_W +: DATA_W];
        sub_sel      = req_sub[i];
      end
    end
  end

  // Next-state logic: IDLE grants, EXEC settles the shared unit, RESP waits for acceptance
  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    id_d             = id_q;
    fpu_a_d          = fpu_a_q;
    fpu_b_d          = fpu_b_q;
    fpu_sub_d        = fpu_sub_q;
    resp_valid_d     = resp_valid_q;
    resp_id_d        = resp_id_q;
    resp_result_d    = resp_result_q;
    resp_exception_d = resp_exception_q;
    case (state_q)
      IDLE: begin
        if (grant) state_d = EXEC;
      end
      EXEC: begin
        resp_result_d    = fpu_result;
        resp_exception_d = fpu_exception;
        resp_id_d        = id_q;
        resp_valid_d     = 1'b1;
        state_d          = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = grant ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // grant can only be true in IDLE, or in RESP on acceptance when back-to-back is enabled
    if (grant) begin
      fpu_a_d   = a_sel;
      fpu_b_d   = b_sel;
      fpu_sub_d = sub_sel;
      id_d      = win_idx;
      rr_ptr_d  = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= IDLE;
      rr_ptr_q         <= '0;
      id_q             <= '0;
      fpu_a_q          <= '0;
      fpu_b_q          <= '0;
      fpu_sub_q        <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_id_q        <= '0;
      resp_result_q    <= '0;
      resp_exception_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      id_q             <= id_d;
      fpu_a_q          <= fpu_a_d;
      fpu_b_q          <= fpu_b_d;
      fpu_sub_q        <= fpu_sub_d;
      resp_valid_q     <= resp_valid_d;
      resp_id_q        <= resp_id_d;
      resp_result_q    <= resp_result_d;
      resp_exception_q <= resp_exception_d;
    end
  end

  assign fpu_a          = fpu_a_q;
  assign fpu_b          = fpu_b_q;
  assign fpu_sub        = fpu_sub_q;
  assign resp_valid     = resp_valid_q;
  assign resp_id        = resp_id_q;
  assign resp_result    = resp_result_q;
  assign resp_exception = resp_exception_q;
  assign busy           = (state_q != IDLE);

endmodule
